ua_receive: RTL and testbench

//  Serial-to-parallel UART receiver. Pairs with the team's UART transmitter: 8N1 framing, LSB first, idle-high line.

---
 rtl/ua_receive.sv | 145 ++++++++++++++
 tb/tb_ua_receive.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ua_receive.sv
// rtl/ua_receive.sv - 8N1 UART receiver with mid-symbol sampling and a one-entry ready/valid holding register.
// Optional sticky FramingError/Overrun flags are enabled by defining UA_RX_ERR_FLAGS_EN.
module ua_receive #(
  parameter int ClockFreq = 100_000_000,
  parameter int BaudRate  = 115_200
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       SIn,
  output logic [7:0] DataOut,
  output logic       DataOutValid,
  input  logic       DataOutReady
`ifdef UA_RX_ERR_FLAGS_EN
  ,
  output logic       FramingError,
  output logic       Overrun
`endif
);

  localparam int SymbolEdgeTime    = ClockFreq / BaudRate;
  localparam int SampleTime        = SymbolEdgeTime / 2;
  localparam int ClockCounterWidth = (SymbolEdgeTime > 2) ? $clog2(SymbolEdgeTime) : 1;

  localparam logic [ClockCounterWidth-1:0] SampleLast = ClockCounterWidth'(SampleTime - 1);
  localparam logic [ClockCounterWidth-1:0] SymbolLast = ClockCounterWidth'(SymbolEdgeTime - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t                       state, stateNext;
  logic [ClockCounterWidth-1:0] clockCounter, clockCounterNext;
  logic [2:0]                   bitCount, bitCountNext;
  logic [7:0]                   shift, shiftNext;
  logic                         sInMeta, sInS;
  logic                         goodByte, frameErr;
  logic                         transfer;

  assign transfer = DataOutValid && DataOutReady;

  // SIn is asynchronous to Clock; resets to the idle-high line level.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sInMeta <= 1'b1;
      sInS    <= 1'b1;
    end else begin
      sInMeta <= SIn;
      sInS    <= sInMeta;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state        <= IDLE;
      clockCounter <= '0;
      bitCount     <= '0;
      shift        <= '0;
    end else begin
      state        <= stateNext;
      clockCounter <= clockCounterNext;
      bitCount     <= bitCountNext;
      shift        <= shiftNext;
    end
  end

  always_comb begin
    stateNext        = state;
    clockCounterNext = clockCounter;
    bitCountNext     = bitCount;
    shiftNext        = shift;
    goodByte         = 1'b0;
    frameErr         = 1'b0;
    unique case (state)
      IDLE: begin
        clockCounterNext = '0;
        bitCountNext     = '0;
        if (!sInS) stateNext = START;
      end
      START: begin
        if (clockCounter == SampleLast) begin
          clockCounterNext = '0;
          // A line that has returned high by mid-start-bit was a glitch.
          stateNext        = sInS ? IDLE : DATA;
        end else begin
          clockCounterNext = clockCounter + 1'b1;
        end
      end
      DATA: begin
        if (clockCounter == SymbolLast) begin
          clockCounterNext = '0;
          shiftNext        = {sInS, shift[7:1]};
          bitCountNext     = bitCount + 1'b1;
          if (bitCount == 3'd7) stateNext = STOP;
        end else begin
          clockCounterNext = clockCounter + 1'b1;
        end
      end
      STOP: begin
        if (clockCounter == SymbolLast) begin
          clockCounterNext = '0;
          goodByte         = sInS;
          frameErr         = !sInS;
          stateNext        = IDLE;
        end else begin
          clockCounterNext = clockCounter + 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // A byte finishing while the consumer stalls is dropped; the held byte wins.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      DataOut      <= 8'h00;
      DataOutValid <= 1'b0;
    end else if (goodByte && (!DataOutValid || DataOutReady)) begin
      DataOut      <= shift;
      DataOutValid <= 1'b1;
    end else if (transfer) begin
      DataOutValid <= 1'b0;
    end
  end

`ifdef UA_RX_ERR_FLAGS_EN
  logic overrunEvent;
  assign overrunEvent = goodByte && DataOutValid && !DataOutReady;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      FramingError <= 1'b0;
      Overrun      <= 1'b0;
    end else begin
      if (frameErr)          FramingError <= 1'b1;
      else if (transfer)     FramingError <= 1'b0;
      if (overrunEvent)      Overrun      <= 1'b1;
      else if (transfer)     Overrun      <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_ua_receive.sv
// tb/tb_ua_receive.sv - Directed table-driven bench for ua_receive at 10 clocks per bit.
module tb_ua_receive;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       SIn = 1'b1;
  logic [7:0] DataOut;
  logic       DataOutValid;
  logic       DataOutReady = 1'b1;
`ifdef UA_RX_ERR_FLAGS_EN
  logic       FramingError;
  logic       Overrun;
`endif

  ua_receive #(.ClockFreq(1_000_000), .BaudRate(100_000)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .SIn         (SIn),
    .DataOut     (DataOut),
    .DataOutValid(DataOutValid),
    .DataOutReady(DataOutReady)
`ifdef UA_RX_ERR_FLAGS_EN
    ,
    .FramingError(FramingError),
    .Overrun     (Overrun)
`endif
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [7:0] data;
    int         expCount;
  } vec_t;

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         startCyc = 0;
  int         firstValid = -1;
  int         validCount = 0;
  int         holdErr = 0;
  logic       prevHold = 1'b0;
  logic [7:0] prevData = 8'h00;
  logic [7:0] rxQ[$];
  vec_t       vecs[6];

  always @(posedge Clock) cyc++;

  always @(negedge Clock) begin
    if (DataOutValid) begin
      validCount++;
      if (firstValid < 0) firstValid = cyc;
    end
    if (DataOutValid && DataOutReady) rxQ.push_back(DataOut);
    if (Reset && prevHold && (DataOut !== prevData || !DataOutValid)) holdErr++;
    prevHold = DataOutValid && !DataOutReady;
    prevData = DataOut;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic clear_mon();
    rxQ.delete();
    validCount = 0;
    firstValid = -1;
  endtask

  task automatic idle(input int n);
    SIn = 1'b1;
    repeat (n) @(posedge Clock);
    #1;
  endtask

  // Caller is at posedge+1; each bit occupies exactly 10 clocks.
  task automatic send(input logic [7:0] d, input logic stopBit, input int nBits);
    logic [9:0] f;
    f = {stopBit, d, 1'b0};
    startCyc = cyc;
    for (int i = 0; i < nBits; i++) begin
      SIn = f[i];
      repeat (10) @(posedge Clock);
      #1;
    end
  endtask

  initial begin
    vecs[0] = '{8'h55, 1};
    vecs[1] = '{8'h00, 1};
    vecs[2] = '{8'hFF, 1};
    vecs[3] = '{8'h80, 1};
    vecs[4] = '{8'h01, 1};
    vecs[5] = '{8'hC3, 1};

    repeat (3) @(posedge Clock);
    #1;
    check("reset_valid", DataOutValid, 0);
    check("reset_data", DataOut, 0);
`ifdef UA_RX_ERR_FLAGS_EN
    check("reset_ferr", FramingError, 0);
    check("reset_ovr", Overrun, 0);
`endif
    Reset = 1'b1;
    idle(20);

    for (int v = 0; v < 6; v++) begin
      clear_mon();
      send(vecs[v].data, 1'b1, 10);
      idle(10);
      check($sformatf("vec%0d_count", v), rxQ.size(), vecs[v].expCount);
      if (rxQ.size() > 0) check($sformatf("vec%0d_data", v), rxQ[0], vecs[v].data);
      check($sformatf("vec%0d_pulse", v), validCount, 1);
      check($sformatf("vec%0d_latency_ok", v),
            int'((firstValid - startCyc) >= 95 && (firstValid - startCyc) <= 100), 1);
    end

    // Back-pressure: second byte overruns, first byte held stable.
    clear_mon();
    holdErr = 0;
    DataOutReady = 1'b0;
    send(8'hA5, 1'b1, 10);
    send(8'h3C, 1'b1, 10);
    idle(20);
    check("bp_valid", DataOutValid, 1);
    check("bp_data", DataOut, 8'hA5);
    check("bp_hold", holdErr, 0);
`ifdef UA_RX_ERR_FLAGS_EN
    check("bp_overrun", Overrun, 1);
`endif
    DataOutReady = 1'b1;
    @(posedge Clock);
    #1;
    check("bp_count", rxQ.size(), 1);
    if (rxQ.size() > 0) check("bp_first", rxQ[0], 8'hA5);
    check("bp_valid_after", DataOutValid, 0);
`ifdef UA_RX_ERR_FLAGS_EN
    check("bp_overrun_clr", Overrun, 0);
`endif
    idle(10);

    // False start: 3-clock glitch.
    clear_mon();
    SIn = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    idle(30);
    check("glitch_valid", validCount, 0);
`ifdef UA_RX_ERR_FLAGS_EN
    check("glitch_ferr", FramingError, 0);
    check("glitch_ovr", Overrun, 0);
`endif

    // Framing error then recovery.
    clear_mon();
    send(8'hFF, 1'b0, 10);
    idle(20);
    check("ferr_valid", validCount, 0);
`ifdef UA_RX_ERR_FLAGS_EN
    check("ferr_flag", FramingError, 1);
`endif
    send(8'h0F, 1'b1, 10);
    idle(10);
    check("ferr_next_count", rxQ.size(), 1);
    if (rxQ.size() > 0) check("ferr_next_data", rxQ[0], 8'h0F);
`ifdef UA_RX_ERR_FLAGS_EN
    check("ferr_flag_clr", FramingError, 0);
`endif

    // Reset during data bit 4 of 0x81.
    clear_mon();
    send(8'h81, 1'b1, 5);
    SIn = 1'b0;
    repeat (5) @(posedge Clock);
    #1;
    Reset = 1'b0;
    SIn = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    check("rst_mid_valid", DataOutValid, 0);
    check("rst_mid_data", DataOut, 0);
    Reset = 1'b1;
    idle(20);
    check("rst_mid_nobyte", rxQ.size(), 0);
    send(8'h7E, 1'b1, 10);
    idle(10);
    check("rst_next_count", rxQ.size(), 1);
    if (rxQ.size() > 0) check("rst_next_data", rxQ[0], 8'h7E);

    // Back-to-back frames with no idle bits.
    clear_mon();
    send(8'h12, 1'b1, 10);
    send(8'h34, 1'b1, 10);
    idle(10);
    check("b2b_count", rxQ.size(), 2);
    if (rxQ.size() > 1) begin
      check("b2b_first", rxQ[0], 8'h12);
      check("b2b_second", rxQ[1], 8'h34);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
